// File: rtl/vip_pkg.sv
// Shared definitions for the VIP synthetic frame source: FSM state encoding,
// test-pattern codes and counter-width helpers.
package vip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } vip_state_e;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_CONST = 2'd3;

  // A counter for a single value still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vip_pattern_gen.sv
// Registered luminance generator: loads a new pattern value on each pixel
// strobe, holds it between strobes and clears it outside active pixels.
module vip_pattern_gen
  import vip_pkg::*;
#(
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int CHECK_LOG2 = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [1:0]     pattern_sel,
  input  logic [7:0]     const_y,
  input  logic           pix_valid,
  input  logic           pix_strobe,
  output logic [7:0]     pix_y
);

  logic [7:0] pix_q, pix_d;
  logic [7:0] pattern_val;
  logic       check_bit;

  always_comb begin
    check_bit = 1'(x >> CHECK_LOG2) ^ 1'(y >> CHECK_LOG2);
    case (pattern_sel)
      PAT_HRAMP: pattern_val = 8'(x);
      PAT_VRAMP: pattern_val = 8'(y);
      PAT_CHECK: pattern_val = check_bit ? 8'hFF : 8'h00;
      default:   pattern_val = const_y;
    endcase

    pix_d = pix_q;
    if (!pix_valid) begin
      pix_d = 8'h00;
    end else if (pix_strobe) begin
      pix_d = pattern_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= 8'h00;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign pix_y = pix_q;

endmodule

// File: rtl/vip_frame_source.sv
// Synthetic video transmitter for the VIP pipeline: frame/line timing FSM,
// pixel pacing and registered vsync/href/clken/luminance outputs.
module vip_frame_source
  import vip_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 160,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 2,
  parameter int V_BACK      = 8,
  parameter int V_FRONT     = 2,
  parameter int CLK_DIV     = 2,
  parameter int CHECK_LOG2  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  input  logic [7:0] const_y,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_y,
  output logic       frame_done,
  output logic       busy
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_MAX   = max_of(max_of(VSYNC_LINES, V_BACK), max_of(V_ACTIVE, V_FRONT));
  localparam int DIV_W   = cnt_width(CLK_DIV);
  localparam int H_W     = cnt_width(H_TOTAL);
  localparam int V_W     = cnt_width(V_MAX);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT_END  = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0]   FRONT_LAST = V_W'(V_FRONT - 1);

  vip_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [H_W-1:0]   h_q, h_d;
  logic [V_W-1:0]   v_q, v_d;
  logic [1:0]       pat_q, pat_d;
  logic [7:0]       const_q, const_d;
  logic             vsync_q, vsync_d;
  logic             href_q, href_d;
  logic             clken_q, clken_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  int   state_lines;
  logic slot_last, line_end, state_end;

  always_comb begin
    case (state_q)
      ST_VSYNC:  state_lines = VSYNC_LINES;
      ST_VBACK:  state_lines = V_BACK;
      ST_ACTIVE: state_lines = V_ACTIVE;
      ST_VFRONT: state_lines = V_FRONT;
      default:   state_lines = 1;
    endcase
  end

  assign slot_last = (div_q == DIV_LAST);
  assign line_end  = slot_last && (h_q == H_LAST);
  assign state_end = line_end && (v_q == V_W'(state_lines - 1));

  // Counters ripple slot_div -> h_cnt -> v_cnt; v_cnt restarts in every state.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    h_d     = h_q;
    v_d     = v_q;
    pat_d   = pat_q;
    const_d = const_q;

    if (state_q == ST_IDLE) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
      if (enable) begin
        state_d = ST_VSYNC;
      end
    end else if (!slot_last) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d = '0;
      if (h_q != H_LAST) begin
        h_d = h_q + H_W'(1);
      end else begin
        h_d = '0;
        if (!state_end) begin
          v_d = v_q + V_W'(1);
        end else begin
          v_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBACK;
            ST_VBACK:  state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFRONT;
            default:   state_d = enable ? ST_VSYNC : ST_IDLE;
          endcase
        end
      end
    end

    if ((state_d == ST_VSYNC) && (state_q != ST_VSYNC)) begin
      pat_d   = pattern_sel;
      const_d = const_y;
    end
  end

  // Outputs are decoded from the next-cycle position so the flops line up with it.
  always_comb begin
    vsync_d = (state_d == ST_VSYNC);
    href_d  = (state_d == ST_ACTIVE) && (h_d < H_ACT_END);
    clken_d = href_d && (div_d == '0);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_VFRONT) && (div_d == DIV_LAST) &&
              (h_d == H_LAST) && (v_d == FRONT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      pat_q   <= PAT_HRAMP;
      const_q <= 8'h00;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      clken_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pat_q   <= pat_d;
      const_q <= const_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      clken_q <= clken_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  vip_pattern_gen #(
    .X_W       (H_W),
    .Y_W       (V_W),
    .CHECK_LOG2(CHECK_LOG2)
  ) u_pattern (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (h_d),
    .y          (v_d),
    .pattern_sel(pat_q),
    .const_y    (const_q),
    .pix_valid  (href_d),
    .pix_strobe (clken_d),
    .pix_y      (post_img_y)
  );

  assign post_frame_vsync = vsync_q;
  assign post_frame_href  = href_q;
  assign post_frame_clken = clken_q;
  assign frame_done       = done_q;
  assign busy             = busy_q;

endmodule
